// File: rtl/scan_display_ctrl.sv
// Multiplexed common-anode seven-segment scan controller.
// Frame-coherent shadow capture, dead time, PWM dimming, zero blanking.
module scan_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_CYC   = 208333,
  parameter int DEAD_CYC   = 1000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_start
);

  localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [SW-1:0] DEAD_END  = SW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [SW-1:0]           r_slot;
  logic [IW-1:0]           r_idx;
  logic [BRIGHT_W-1:0]     r_pwm;

  logic [4*NUM_DIGITS-1:0] r_data_s;
  logic [NUM_DIGITS-1:0]   r_dp_s;
  logic [NUM_DIGITS-1:0]   r_en_s;
  logic                    r_lz_s;
  logic [BRIGHT_W-1:0]     r_br_s;

  logic [NUM_DIGITS-1:0]   r_anode;
  logic [7:0]              r_cathode;
  logic                    r_frame;

  logic                    w_cap;
  logic                    w_wrap;
  logic                    w_pwm_on;
  logic                    w_lit;
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_cur;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_anode_n;
  logic [7:0]              w_cath_n;

  assign w_cap  = (r_slot == '0) && (r_idx == '0);
  assign w_wrap = (r_slot == SLOT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
      r_idx  <= '0;
      r_pwm  <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_wrap) begin
        r_slot <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  // Shadows only move at frame start so a frame never mixes old/new data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_s <= '0;
      r_dp_s   <= '0;
      r_en_s   <= '0;
      r_lz_s   <= 1'b0;
      r_br_s   <= '0;
    end else if (w_cap) begin
      r_data_s <= data;
      r_dp_s   <= dp;
      r_en_s   <= digit_en;
      r_lz_s   <= lz_blank;
      r_br_s   <= brightness;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign w_nib[i] = r_data_s[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign w_blank[i] = 1'b0;
    end else begin : g_hi
      assign w_blank[i] = r_lz_s &&
        (r_data_s[4*NUM_DIGITS-1:4*i] == '0);
    end
  end

  assign w_cur    = w_nib[r_idx];
  assign w_pwm_on = (r_br_s == '1) || (r_pwm < r_br_s);
  assign w_lit    = (r_slot >= DEAD_END) && r_en_s[r_idx] &&
                    !w_blank[r_idx] && w_pwm_on;

  always_comb begin
    w_seg = 7'b1111111;
    unique case (w_cur)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
    endcase
  end

  always_comb begin
    w_anode_n = '1;
    w_cath_n  = 8'hFF;
    if (w_lit) begin
      w_anode_n[r_idx] = 1'b0;
      w_cath_n = {~r_dp_s[r_idx], w_seg};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_anode   <= '1;
      r_cathode <= 8'hFF;
      r_frame   <= 1'b0;
    end else begin
      r_anode   <= w_anode_n;
      r_cathode <= w_cath_n;
      r_frame   <= w_cap;
    end
  end

  assign anode       = r_anode;
  assign cathode     = r_cathode;
  assign frame_start = r_frame;

endmodule
